// File: rtl/i_cache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package i_cache_pkg;

    localparam int unsigned INST_LEN          = 32;
    localparam int unsigned ICACHE_INDEX_BITS = 7;

    typedef enum logic {
        IC_IDLE   = 1'b0,
        IC_REFILL = 1'b1
    } ic_state_e;

    localparam logic STALL        = 1'b1;
    localparam logic NO_STALL     = 1'b0;
    localparam logic RESET_ENABLE = 1'b0;

    // Stored tag width: everything above the index and the byte offset.
    function automatic int unsigned icache_tag_bits(input int unsigned addr_w,
                                                    input int unsigned index_w);
        return addr_w - index_w - 2;
    endfunction

endpackage

// File: rtl/i_cache_array.sv
// Valid/tag/data line storage: combinational read, single write, flush-all.
module i_cache_array
    import i_cache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int unsigned TAG_BITS   = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] waddr_i,
    input  logic [TAG_BITS-1:0]   wtag_i,
    input  logic [INST_LEN-1:0]   wdata_i,
    input  logic [INDEX_BITS-1:0] raddr_i,
    output logic                  rvalid_o,
    output logic [TAG_BITS-1:0]   rtag_o,
    output logic [INST_LEN-1:0]   rdata_o
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [INST_LEN-1:0] data_q [LINES];

    // Flush wins over a same-cycle fill so a fenced line never appears valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RESET_ENABLE) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[waddr_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[waddr_i]  <= wtag_i;
            data_q[waddr_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[raddr_i];
    assign rtag_o   = tag_q[raddr_i];
    assign rdata_o  = data_q[raddr_i];

endmodule

// File: rtl/i_cache.sv
// Direct-mapped instruction cache: same-cycle hits, single outstanding refill
// with a bypass of the returning word to the fetch stage.
module i_cache
    import i_cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  flush,
    output logic                  inst_valid,
    output logic [INST_LEN-1:0]   inst,
    output logic                  stallreq_if,
    output logic                  mc_req,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    input  logic                  mc_done,
    input  logic [INST_LEN-1:0]   mc_data
);

    localparam int unsigned TAG_BITS = icache_tag_bits(ADDR_WIDTH, INDEX_BITS);

    ic_state_e             state_q, state_d;
    logic                  mc_req_q, mc_req_d;
    logic [ADDR_WIDTH-1:0] mc_addr_q, mc_addr_d;

    logic [INDEX_BITS-1:0] idx, fill_idx;
    logic [TAG_BITS-1:0]   tag, fill_tag, rd_tag;
    logic                  rd_valid;
    logic [INST_LEN-1:0]   rd_data;
    logic                  hit, fill_done, bypass, fill_we;
    logic                  unused_addr_bits;

    assign idx              = if_addr[INDEX_BITS+1:2];
    assign tag              = if_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign fill_idx         = mc_addr_q[INDEX_BITS+1:2];
    assign fill_tag         = mc_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
    assign unused_addr_bits = ^if_addr[1:0];

    i_cache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst),
        .flush_i  (flush),
        .we_i     (fill_we),
        .waddr_i  (fill_idx),
        .wtag_i   (fill_tag),
        .wdata_i  (mc_data),
        .raddr_i  (idx),
        .rvalid_o (rd_valid),
        .rtag_o   (rd_tag),
        .rdata_o  (rd_data)
    );

    // Lookup, bypass and next-state; the returning word is forwarded only if
    // the fetch still targets the word being refilled.
    always_comb begin
        state_d   = state_q;
        mc_req_d  = mc_req_q;
        mc_addr_d = mc_addr_q;
        fill_we   = 1'b0;

        hit       = if_req && rd_valid && (rd_tag == tag) && (state_q == IC_IDLE);
        fill_done = (state_q == IC_REFILL) && mc_done;
        bypass    = fill_done && if_req &&
                    (if_addr[ADDR_WIDTH-1:2] == mc_addr_q[ADDR_WIDTH-1:2]);

        unique case (state_q)
            IC_IDLE: begin
                if (if_req && !hit) begin
                    state_d   = IC_REFILL;
                    mc_req_d  = 1'b1;
                    mc_addr_d = {if_addr[ADDR_WIDTH-1:2], 2'b00};
                end
            end
            IC_REFILL: begin
                if (mc_done) begin
                    state_d  = IC_IDLE;
                    mc_req_d = 1'b0;
                    fill_we  = 1'b1;
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_ENABLE) begin
            state_q   <= IC_IDLE;
            mc_req_q  <= 1'b0;
            mc_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            mc_req_q  <= mc_req_d;
            mc_addr_q <= mc_addr_d;
        end
    end

    assign mc_req     = mc_req_q;
    assign mc_addr    = mc_addr_q;
    assign inst_valid = hit || bypass;
    assign inst       = bypass ? mc_data : (hit ? rd_data : '0);

    // Reset masks the stall so the pipeline is not held while the cache is cleared.
    always_comb begin
        stallreq_if = NO_STALL;
        if (rst != RESET_ENABLE) begin
            if (state_q == IC_REFILL) begin
                stallreq_if = bypass ? NO_STALL : STALL;
            end else if (if_req && !hit) begin
                stallreq_if = STALL;
            end
        end
    end

endmodule

// File: tb/tb_i_cache.sv
// Self-checking bench for i_cache: directed scenarios plus a randomized run
// against a word-address-keyed reference model.
module tb_i_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst;
    logic        stallreq_if;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    i_cache dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .flush       (flush),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .stallreq_if (stallreq_if),
        .mc_req      (mc_req),
        .mc_addr     (mc_addr),
        .mc_done     (mc_done),
        .mc_data     (mc_data)
    );

    // Reference model: each line remembers the full word address it holds.
    bit          m_valid [128];
    logic [29:0] m_word  [128];
    logic [31:0] m_data  [128];
    bit          m_busy;
    logic [31:0] m_addr;

    logic        e_iv, e_stall, e_req;
    logic [31:0] e_inst, e_maddr;
    logic        o_iv, o_stall, o_req;
    logic [31:0] o_inst, o_maddr;

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_busy = 1'b0;
        m_addr = 32'h0;
    endtask

    // One clock: drive inputs, predict and sample the same-cycle response,
    // clock, advance the model, then sample the refill port.
    task automatic step(input logic req, input logic [31:0] addr, input logic fl,
                        input logic done, input logic [31:0] data);
        int  idx;
        int  fidx;
        bit  hit;
        bit  byp;
        if_req  = req;
        if_addr = addr;
        flush   = fl;
        mc_done = done;
        mc_data = data;
        idx = int'(addr[8:2]);
        hit = !m_busy && req && m_valid[idx] && (m_word[idx] == addr[31:2]);
        byp = m_busy && done && req && (addr[31:2] == m_addr[31:2]);
        e_iv    = hit || byp;
        e_inst  = byp ? data : (hit ? m_data[idx] : 32'h0);
        e_stall = m_busy ? !byp : (req && !hit);
        #1;
        o_iv = inst_valid; o_inst = inst; o_stall = stallreq_if;
        @(posedge clk);
        if (fl) foreach (m_valid[i]) m_valid[i] = 1'b0;
        if (m_busy && done) begin
            fidx = int'(m_addr[8:2]);
            m_data[fidx]  = data;
            m_word[fidx]  = m_addr[31:2];
            m_valid[fidx] = !fl;
            m_busy = 1'b0;
        end else if (!m_busy && req && !hit) begin
            m_busy = 1'b1;
            m_addr = {addr[31:2], 2'b00};
        end
        e_req   = m_busy;
        e_maddr = m_addr;
        #1;
        o_req = mc_req; o_maddr = mc_addr;
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req = 1'b0; if_addr = 32'h0; flush = 1'b0;
        mc_done = 1'b0; mc_data = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        if_req = 1'b1;
        #1;
        checks++; if (stallreq_if !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stallreq_if); end
        checks++; if (inst_valid !== 1'b0 || inst !== 32'h0) begin failures++; $display("FAIL reset_inst: got v=%b %h want 0/0", inst_valid, inst); end
        checks++; if (mc_req !== 1'b0 || mc_addr !== 32'h0) begin failures++; $display("FAIL reset_mc: got %b %h want 0/0", mc_req, mc_addr); end
        if_req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_miss_refill();
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (o_stall !== 1'b1 || o_iv !== 1'b0) begin failures++; $display("FAIL miss_stall: got s=%b v=%b want 1/0", o_stall, o_iv); end
        checks++; if (o_req !== 1'b1 || o_maddr !== 32'h0) begin failures++; $display("FAIL miss_issue: got %b %h want 1/00000000", o_req, o_maddr); end
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (o_stall !== 1'b1 || o_req !== 1'b1) begin failures++; $display("FAIL refill_wait: got s=%b r=%b want 1/1", o_stall, o_req); end
        step(1'b1, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
        checks++; if (o_iv !== 1'b1 || o_inst !== 32'h13 || o_stall !== 1'b0) begin failures++; $display("FAIL bypass: got v=%b %h s=%b want 1/00000013/0", o_iv, o_inst, o_stall); end
        checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL refill_drop: got %b want 0", o_req); end
    endtask

    task automatic test_hit();
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (o_iv !== 1'b1 || o_inst !== 32'h13 || o_stall !== 1'b0) begin failures++; $display("FAIL hit: got v=%b %h s=%b want 1/00000013/0", o_iv, o_inst, o_stall); end
        checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL hit_no_req: got %b want 0", o_req); end
    endtask

    task automatic test_conflict();
        step(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        checks++; if (o_stall !== 1'b1 || o_maddr !== 32'h200) begin failures++; $display("FAIL conflict_miss: got s=%b %h want 1/00000200", o_stall, o_maddr); end
        step(1'b1, 32'h200, 1'b0, 1'b1, 32'h0000_AAAA);
        checks++; if (o_inst !== 32'hAAAA || o_iv !== 1'b1) begin failures++; $display("FAIL conflict_fill: got v=%b %h want 1/0000aaaa", o_iv, o_inst); end
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (o_stall !== 1'b1 || o_maddr !== 32'h0 || o_req !== 1'b1) begin failures++; $display("FAIL evicted: got s=%b r=%b %h want 1/1/00000000", o_stall, o_req, o_maddr); end
        step(1'b1, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
    endtask

    task automatic test_redirect();
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        checks++; if (o_maddr !== 32'h4) begin failures++; $display("FAIL redir_issue: got %h want 00000004", o_maddr); end
        step(1'b1, 32'h100, 1'b0, 1'b1, 32'h0000_0022);
        checks++; if (o_stall !== 1'b1 || o_iv !== 1'b0) begin failures++; $display("FAIL redir_no_bypass: got s=%b v=%b want 1/0", o_stall, o_iv); end
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        checks++; if (o_stall !== 1'b1 || o_maddr !== 32'h100 || o_req !== 1'b1) begin failures++; $display("FAIL redir_fresh: got s=%b r=%b %h want 1/1/00000100", o_stall, o_req, o_maddr); end
        step(1'b1, 32'h100, 1'b0, 1'b1, 32'h0000_0033);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        checks++; if (o_iv !== 1'b1 || o_inst !== 32'h22) begin failures++; $display("FAIL redir_line1: got v=%b %h want 1/00000022", o_iv, o_inst); end
    endtask

    task automatic test_flush();
        step(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (o_iv !== 1'b1 || o_inst !== 32'h13) begin failures++; $display("FAIL flush_preflush_hit: got v=%b %h want 1/00000013", o_iv, o_inst); end
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL flush_miss0: got %b want 1", o_stall); end
        step(1'b1, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL flush_miss4: got %b want 1", o_stall); end
        step(1'b1, 32'h4, 1'b1, 1'b1, 32'h0000_0044);
        checks++; if (o_iv !== 1'b1 || o_inst !== 32'h44 || o_stall !== 1'b0) begin failures++; $display("FAIL flush_fill_bypass: got v=%b %h s=%b want 1/00000044/0", o_iv, o_inst, o_stall); end
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        checks++; if (o_stall !== 1'b1 || o_iv !== 1'b0) begin failures++; $display("FAIL flush_fill_invalid: got s=%b v=%b want 1/0", o_stall, o_iv); end
        step(1'b1, 32'h4, 1'b0, 1'b1, 32'h0000_0044);
    endtask

    task automatic test_reset_mid_refill();
        step(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        checks++; if (o_req !== 1'b1) begin failures++; $display("FAIL midrst_pre: got %b want 1", o_req); end
        rst = 1'b0;
        #1;
        checks++; if (mc_req !== 1'b0 || mc_addr !== 32'h0) begin failures++; $display("FAIL midrst_async: got %b %h want 0/00000000", mc_req, mc_addr); end
        model_reset();
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_DEAD);
        checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL stray_done: got %b want 0", o_req); end
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (o_stall !== 1'b1 || o_iv !== 1'b0) begin failures++; $display("FAIL midrst_miss: got s=%b v=%b want 1/0", o_stall, o_iv); end
        step(1'b1, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic        req, fl, done;
        for (int n = 0; n < 600; n++) begin
            addr = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 7)) << 2)
                 | 32'($urandom_range(0, 3));
            req  = ($urandom_range(0, 9) < 8);
            fl   = ($urandom_range(0, 19) == 0);
            done = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            step(req, addr, fl, done, $urandom);
            checks++;
            if (o_iv !== e_iv || o_inst !== e_inst || o_stall !== e_stall) begin
                failures++;
                $display("FAIL rand_lookup n=%0d addr=%h: got v=%b %h s=%b want v=%b %h s=%b",
                         n, addr, o_iv, o_inst, o_stall, e_iv, e_inst, e_stall);
            end
            checks++;
            if (o_req !== e_req || o_maddr !== e_maddr) begin
                failures++;
                $display("FAIL rand_mc n=%0d: got %b %h want %b %h", n, o_req, o_maddr, e_req, e_maddr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_miss_refill();
        test_hit();
        test_conflict();
        test_redirect();
        test_flush();
        test_reset_mid_refill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
